// File: rtl/reg_file_mp.sv
// Parametrised MIPS-style register bank with a post-reset sequential clear,
// a ready handshake, optional same-cycle write bypass and a sticky dropped-write flag.
module reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int READ_PORTS = 2,
  parameter int BYPASS     = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             reg_write,
  input  logic [ADDR_WIDTH-1:0]            write_reg,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_addr,
  output logic [READ_PORTS*DATA_WIDTH-1:0] read_data,
  output logic                             ready,
  output logic                             write_dropped
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH:0]   REG_LIMIT = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_idx;
  logic [DATA_WIDTH-1:0]   regs [1:NUM_REGS-1];
  logic                    write_ok;

  assign write_ok = reg_write && (write_reg != '0) && ({1'b0, write_reg} < REG_LIMIT);

  // Clear engine walks registers 1..NUM_REGS-1 once, then the bank opens for writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= CLEAR;
      clr_idx       <= ADDR_WIDTH'(1);
      ready         <= 1'b0;
      write_dropped <= 1'b0;
    end else if (state == CLEAR) begin
      if (reg_write) write_dropped <= 1'b1;
      if (clr_idx == LAST_IDX) begin
        state <= READY;
        ready <= 1'b1;
      end else begin
        clr_idx <= clr_idx + 1'b1;
      end
    end
  end

  // Register 0 has no storage; reset itself leaves the contents alone.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == CLEAR)
        regs[clr_idx[IDX_W-1:0]] <= '0;
      else if (write_ok)
        regs[write_reg[IDX_W-1:0]] <= write_data;
    end
  end

  always_comb begin
    logic [ADDR_WIDTH-1:0] addr;
    addr      = '0;
    read_data = '0;
    for (int i = 0; i < READ_PORTS; i++) begin
      addr = read_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (state == READY) begin
        if (BYPASS != 0 && write_ok && addr == write_reg)
          read_data[i*DATA_WIDTH +: DATA_WIDTH] = write_data;
        else if (addr != '0 && {1'b0, addr} < REG_LIMIT)
          read_data[i*DATA_WIDTH +: DATA_WIDTH] = regs[addr[IDX_W-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized self-checking bench for reg_file_mp: three instances (bypass on, bypass off,
// 16x16 with three ports) compared every cycle against a behavioural bank model.
module tb_reg_file_mp;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        a_we;
  logic [4:0]  a_wa;
  logic [31:0] a_wd;
  logic [9:0]  a_ra;
  logic [63:0] a_rd, b_rd;
  logic        a_ready, b_ready, a_drop, b_drop;

  logic        c_we;
  logic [4:0]  c_wa;
  logic [15:0] c_wd;
  logic [14:0] c_ra;
  logic [47:0] c_rd;
  logic        c_ready, c_drop;

  reg_file_mp #(.BYPASS(1)) dut_a (
    .clock(clock), .reset(reset), .reg_write(a_we), .write_reg(a_wa), .write_data(a_wd),
    .read_addr(a_ra), .read_data(a_rd), .ready(a_ready), .write_dropped(a_drop));

  reg_file_mp #(.BYPASS(0)) dut_b (
    .clock(clock), .reset(reset), .reg_write(a_we), .write_reg(a_wa), .write_data(a_wd),
    .read_addr(a_ra), .read_data(b_rd), .ready(b_ready), .write_dropped(b_drop));

  reg_file_mp #(.DATA_WIDTH(16), .NUM_REGS(16), .ADDR_WIDTH(5), .READ_PORTS(3), .BYPASS(1)) dut_c (
    .clock(clock), .reset(reset), .reg_write(c_we), .write_reg(c_wa), .write_data(c_wd),
    .read_addr(c_ra), .read_data(c_rd), .ready(c_ready), .write_dropped(c_drop));

  int total = 0;
  int bad   = 0;
  int sweep = 0;

  // Model: index 0 covers dut_a/dut_b (32 regs), index 1 covers dut_c (16 regs).
  logic [31:0] mreg [2][32];
  int          mcnt [2];
  bit          mdrop [2];

  function automatic int nregs(int cfg);
    return (cfg != 0) ? 16 : 32;
  endfunction

  function automatic logic [31:0] expRead(int cfg, int addr, bit byp, bit we, int wa, logic [31:0] wd);
    int n = nregs(cfg);
    if (mcnt[cfg] < n - 1) return 32'h0;
    if (addr == 0 || addr >= n) return 32'h0;
    if (byp && we && wa == addr) return wd;
    return mreg[cfg][addr];
  endfunction

  task automatic modelStep(int cfg, bit we, int wa, logic [31:0] wd);
    int n = nregs(cfg);
    if (mcnt[cfg] < n - 1) begin
      if (we) mdrop[cfg] = 1'b1;
      mcnt[cfg]++;
      if (mcnt[cfg] == n - 1)
        for (int r = 0; r < 32; r++) mreg[cfg][r] = 32'h0;
    end else if (we && wa != 0 && wa < n) begin
      mreg[cfg][wa] = wd;
    end
  endtask

  task automatic checkOutput(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll(string tag);
    logic [31:0] rdy0, rdy1;
    rdy0 = (mcnt[0] >= 31) ? 32'd1 : 32'd0;
    rdy1 = (mcnt[1] >= 15) ? 32'd1 : 32'd0;
    checkOutput({tag, " a.ready"}, {31'h0, a_ready}, rdy0);
    checkOutput({tag, " b.ready"}, {31'h0, b_ready}, rdy0);
    checkOutput({tag, " c.ready"}, {31'h0, c_ready}, rdy1);
    checkOutput({tag, " a.drop"}, {31'h0, a_drop}, {31'h0, mdrop[0]});
    checkOutput({tag, " b.drop"}, {31'h0, b_drop}, {31'h0, mdrop[0]});
    checkOutput({tag, " c.drop"}, {31'h0, c_drop}, {31'h0, mdrop[1]});
    for (int p = 0; p < 2; p++) begin
      checkOutput($sformatf("%s a.rd%0d", tag, p), a_rd[p*32 +: 32],
                  expRead(0, a_ra[p*5 +: 5], 1'b1, a_we, a_wa, a_wd));
      checkOutput($sformatf("%s b.rd%0d", tag, p), b_rd[p*32 +: 32],
                  expRead(0, a_ra[p*5 +: 5], 1'b0, a_we, a_wa, a_wd));
    end
    for (int p = 0; p < 3; p++)
      checkOutput($sformatf("%s c.rd%0d", tag, p), {16'h0, c_rd[p*16 +: 16]},
                  expRead(1, c_ra[p*5 +: 5], 1'b1, c_we, c_wa, {16'h0, c_wd}));
  endtask

  // Called just after a falling edge with inputs already driven; returns after the next one.
  task automatic applyStimulus(string tag);
    #1 checkAll(tag);
    @(posedge clock);
    if (!reset) begin
      modelStep(0, a_we, a_wa, a_wd);
      modelStep(1, c_we, c_wa, {16'h0, c_wd});
    end
    @(negedge clock);
  endtask

  task automatic pulseReset();
    a_we  = 1'b0;
    c_we  = 1'b0;
    reset = 1'b1;
    #1;
    mcnt  = '{0, 0};
    mdrop = '{1'b0, 1'b0};
    checkAll("reset");
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic idle(int n, string tag);
    for (int k = 0; k < n; k++) begin
      a_we = 1'b0;
      c_we = 1'b0;
      a_ra = {5'(31 - (sweep % 32)), 5'(sweep % 32)};
      c_ra = {5'((sweep + 7) % 32), 5'(31 - (sweep % 32)), 5'(sweep % 32)};
      sweep++;
      applyStimulus(tag);
    end
  endtask

  initial begin
    a_we = 0; a_wa = 0; a_wd = 0; a_ra = 0;
    c_we = 0; c_wa = 0; c_wd = 0; c_ra = 0;
    @(negedge clock);
    pulseReset();

    // Clear latency: 15 edges for the 16-register bank, 31 for the default bank.
    idle(14, "clear");
    #1 checkOutput("c_not_ready_14", {31'h0, c_ready}, 32'd0);
    idle(1, "clear");
    #1 checkOutput("c_ready_15", {31'h0, c_ready}, 32'd1);
    idle(15, "clear");
    #1 checkOutput("a_not_ready_30", {31'h0, a_ready}, 32'd0);
    idle(1, "clear");
    #1 checkOutput("a_ready_31", {31'h0, a_ready}, 32'd1);
    idle(32, "zeroes");

    a_we = 1; a_wa = 7; a_wd = 32'hDEADBEEF; a_ra = 0;
    c_we = 1; c_wa = 20; c_wd = 16'h1234; c_ra = {5'd20, 5'd20, 5'd20};
    applyStimulus("wr7");
    a_we = 0; a_ra = {5'd7, 5'd7};
    c_we = 1; c_wa = 15; c_wd = 16'hBEEF; c_ra = {5'd20, 5'd20, 5'd20};
    #1 checkOutput("rd7_p0", a_rd[31:0], 32'hDEADBEEF);
    checkOutput("rd7_p1", a_rd[63:32], 32'hDEADBEEF);
    checkOutput("c_rd20", {16'h0, c_rd[15:0]}, 32'h0);
    checkOutput("c_drop_hi_addr", {31'h0, c_drop}, 32'd0);
    applyStimulus("rd7");
    a_we = 1; a_wa = 0; a_wd = 32'h12345678; a_ra = {5'd0, 5'd0};
    c_we = 0; c_ra = {5'd15, 5'd15, 5'd15};
    #1 checkOutput("c_rd15_p0", {16'h0, c_rd[15:0]}, 32'hBEEF);
    checkOutput("c_rd15_p2", {16'h0, c_rd[47:32]}, 32'hBEEF);
    applyStimulus("wr0");
    a_we = 0;
    #1 checkOutput("rd0", a_rd[31:0], 32'h0);
    applyStimulus("rd0");

    a_we = 1; a_wa = 5; a_wd = 32'hA5A5A5A5; a_ra = {5'd5, 5'd0};
    #1 checkOutput("byp_a_pre", a_rd[63:32], 32'hA5A5A5A5);
    checkOutput("byp_b_pre", b_rd[63:32], 32'h0);
    applyStimulus("byp");
    a_we = 0;
    #1 checkOutput("byp_b_post", b_rd[63:32], 32'hA5A5A5A5);
    applyStimulus("byp_post");

    for (int k = 0; k < 400; k++) begin
      a_we = 1'($urandom_range(0, 1));
      a_wa = 5'($urandom_range(0, 31));
      a_wd = $urandom;
      a_ra = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 3) == 0) a_ra[9:5] = a_wa;
      if ($urandom_range(0, 3) == 0) a_ra[4:0] = a_wa;
      c_we = 1'($urandom_range(0, 1));
      c_wa = 5'($urandom_range(0, 31));
      c_wd = 16'($urandom);
      c_ra = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 2) == 0) c_ra = {c_wa, c_wa, c_wa};
      applyStimulus("rand");
    end

    a_we = 1; a_wa = 3; a_wd = 32'h55; c_we = 1; c_wa = 3; c_wd = 16'h55;
    applyStimulus("wr3");
    pulseReset();
    for (int k = 0; k < 3; k++) begin
      a_we = 1; a_wa = 3; a_wd = 32'h99; c_we = 1; c_wa = 3; c_wd = 16'h99;
      applyStimulus("drop");
    end
    idle(28, "drop_clear");
    a_ra = {5'd3, 5'd3}; c_ra = {5'd3, 5'd3, 5'd3};
    #1 checkOutput("drop_sticky", {31'h0, a_drop}, 32'd1);
    checkOutput("reg3_cleared", a_rd[31:0], 32'h0);
    checkOutput("c_drop_sticky", {31'h0, c_drop}, 32'd1);
    idle(4, "post_drop");

    pulseReset();
    idle(9, "pre_abort");
    pulseReset();
    idle(30, "restart");
    #1 checkOutput("restart_not_ready_30", {31'h0, a_ready}, 32'd0);
    idle(1, "restart");
    #1 checkOutput("restart_ready_31", {31'h0, a_ready}, 32'd1);
    idle(32, "restart_zeroes");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised MIPS-style register bank; successor to the fixed 32x32, two-read-port register bank.
- Width, depth and read-port count are configurable; register 0 is hardwired to zero.
- Adds a post-reset sequential clear engine, a `ready` handshake, optional write-to-read bypass and a sticky dropped-write flag.
- Sits between decode (register addresses) and the ALU/writeback path of the datapath.

Parameters:
- DATA_WIDTH, 32, bits per register
- NUM_REGS, 32, number of registers (2..2**ADDR_WIDTH)
- ADDR_WIDTH, 5, register address width
- READ_PORTS, 2, number of independent read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads return stored value only

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- reg_write  input  1  write enable
- write_reg  input  ADDR_WIDTH  write address
- write_data  input  DATA_WIDTH  write data
- read_addr  input  READ_PORTS*ADDR_WIDTH  read addresses; port i = bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- read_data  output  READ_PORTS*DATA_WIDTH  read data; port i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- ready  output  1  bank cleared and accepting writes
- write_dropped  output  1  sticky: a write was attempted while not ready

Behaviour:
- Interface: one clock (`clock`); `reset` is asynchronous and active-high.
- State machine: CLEAR, READY.
- Reset asserted (asynchronously):
  - state=CLEAR, clr_idx=1, ready=0, write_dropped=0.
  - Storage contents are not touched by reset itself.
- CLEAR:
  - Each rising edge: regs[clr_idx]<=0.
  - If clr_idx==NUM_REGS-1, go to READY; else clr_idx++.
  - ready rises after exactly NUM_REGS-1 edges following reset deassertion (31 for defaults).
- CLEAR, reads: every read port returns 0 regardless of address; no bypass.
- CLEAR, writes: ignored; reg_write=1 on any edge in CLEAR sets write_dropped=1.
- Reset mid-clear: returns immediately to CLEAR with clr_idx=1; the clear restarts from the beginning.
- READY, writes: at a rising edge, if reg_write=1, write_reg!=0 and write_reg<NUM_REGS, then regs[write_reg]<=write_data. Otherwise there is no storage change and write_dropped is not set.
- READY, reads: combinational, zero latency; read_data[i] = regs[read_addr[i]].
- Read address 0 always returns 0.
- Read address >= NUM_REGS returns 0.
- Bypass (BYPASS=1, state READY): if reg_write=1, write_reg!=0, write_reg<NUM_REGS and read_addr[i]==write_reg, then read_data[i]=write_data in the same cycle, before the edge.
- Bypass (BYPASS=0): the new value becomes visible the cycle after the edge.
- Multiple read ports on the same address all return identical data, including the bypassed value.
- write_dropped: once set it holds until reset; there is no other clear path.
- Widths: write_data is stored unmodified; no sign extension or truncation.
- Storage: regs[0] may be omitted from storage entirely.

Test Plan:
- Reset then idle, defaults: ready=0 for 31 edges and 1 on edge 31. Reading all addresses 0..31 on any port gives 0; write_dropped=0.
- After ready: write 0xDEADBEEF to reg 7, then reg_write=0 and read_addr port0=7, port1=7 -> both ports 0xDEADBEEF. Write 0x12345678 to reg 0 -> reading reg 0 still gives 0.
- BYPASS=1: reg_write=1, write_reg=5, write_data=0xA5A5A5A5, read_addr port1=5 in the same cycle -> read_data port1=0xA5A5A5A5 before the edge. Repeat with BYPASS=0 -> old value (0) before the edge, 0xA5A5A5A5 after.
- Write reg 3 = 0x55 while ready, then pulse reset for 1 cycle mid-operation. Assert reg_write during CLEAR -> write_dropped=1 and reg 3 reads 0. After ready, write_dropped is still 1 until the next reset.
- Reset asserted when clr_idx=10 -> ready stays 0 for a fresh 31 edges after deassertion; all registers read 0 afterwards.
- NUM_REGS=16, ADDR_WIDTH=5, READ_PORTS=3, DATA_WIDTH=16: ready after 15 edges. Write to reg 20 is ignored with no write_dropped; read of addr 20 gives 0. Write reg 15=0xBEEF -> all three ports on addr 15 return 0xBEEF.
